eirq_ctrl: RTL and testbench
============================

# eirq_ctrl

External interrupt controller sitting directly upstream of the core's external-interrupt input. It collects up to `SRC_NUM` peripheral interrupt lines, latches them as pending, arbitrates by programmable priority against a threshold, and drives a single registered request into the core's `ex_trap_i`. Software configures and services it through a cmd/rsp register port of the same shape as the core's sctr bus, using claim/complete semantics.

## Interface
Parameters:
- `SRC_NUM`, 8: number of sources, range 1..31. Source ID = bit index + 1; ID 0 means "none".
- `PRIO_W`, 3: priority and threshold width in bits.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `irq_src_i` in SRC_NUM: peripheral interrupt lines, already in the `clk` domain.
- `ex_trap_o` in-to-core out 1: interrupt request, connects to the core's `ex_trap_i`.
- `cmd_addr` in 32: byte address; only `[7:0]` are decoded.
- `cmd_wdata` in 32: write data.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_wem` in 4: byte write mask.
- `cmd_valid` in 1: command valid.
- `cmd_ready` out 1: command accepted when high with `cmd_valid`.
- `rsp_rdata` out 32: read data.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumed.
- `rsp_error` out 1: unmapped-address response.

## Operation
Register map (word-aligned; `addr[1:0]` ignored):
- 0x00 PENDING: read-only, bit i = pending of ID i+1.
- 0x04 ENABLE: read/write, bit i enables ID i+1.
- 0x08 THRESHOLD: read/write, `[PRIO_W-1:0]`.
- 0x0C CLAIM/COMPLETE:
  - Read returns the winning ID (0 if none), clears that ID's pending bit, and sets its in-service bit.
  - Write of `wdata[4:0]` completes that ID by clearing in-service. A write for an ID that is not in service, or is out of range, is ignored with no error.
- 0x10 TRIG: read/write, bit i: 1 = edge, 0 = level.
- 0x40 + 4·(ID−1) PRIO: read/write, `[PRIO_W-1:0]`.
- All other offsets are unmapped: `rsp_error` = 1, `rsp_rdata` = 0, and writes have no effect.
- Writes to RW registers apply `cmd_wem` per byte. Writes to PENDING are ignored.

Gateway, per source:
- Level mode: pending is set when the line is high and the source is not in service.
- Edge mode: pending is set on a 0→1 transition of the line. It is set even while the source is in service, but the source cannot be claimed until completed.
- If a set and a claim-clear hit the same ID in the same cycle:
  - edge mode: the set wins;
  - level mode: the clear wins, and the source re-pends only after complete.

Arbitration:
- Candidate condition: pending & enable & !in-service & prio > threshold.
- The highest prio wins; ties go to the lowest ID. Prio 0 never interrupts.
- `ex_trap_o` is registered as `|candidates`.
- The claim value is taken from the registered winner.

Bus:
- At most one transaction outstanding; `cmd_ready = !rsp_valid`.
- Claim and write side effects occur in the accept cycle.

## Timing
- Reset values: all registers 0, `ex_trap_o` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_error` = 0. `cmd_ready` = 1 once out of reset.
- Latency from source edge or level to `ex_trap_o`: 2 cycles.
  - Cycle N: source asserted.
  - Cycle N+1: pending set, and the winner is registered at the end of the cycle.
  - Cycle N+2: `ex_trap_o` = 1.
- After a claim is accepted in cycle N, `ex_trap_o` reflects the updated candidates in cycle N+2.
- Responses:
  - The response appears the cycle after accept.
  - `rsp_valid`, `rsp_rdata` and `rsp_error` are held stable until `rsp_ready`.
  - A new command is accepted the cycle after `rsp_valid & rsp_ready`.
- A reset asserted mid-transaction drops the response. The requester must not expect completion.

## Configuration
- `EIRQ_EDGE_EN` defined: TRIG register and edge detection are implemented as described.
- `EIRQ_EDGE_EN` undefined:
  - all sources are level-only;
  - TRIG reads 0, and writes to it are ignored without error;
  - no edge-detect flops are built.

## Structure
- Register offsets (`EIRQ_PENDING`, `EIRQ_ENABLE`, `EIRQ_THRESH`, `EIRQ_CLAIM`, `EIRQ_TRIG`, `EIRQ_PRIO_BASE`) go in the shared defines header alongside the other memory-map constants.
- One sub-module, `eirq_gateway`, holds the per-source pending, in-service and edge logic. It is instantiated `SRC_NUM` times by generate.
- Arbitration and the register file stay in `eirq_ctrl`.

## Test plan
- **Level source:** ENABLE = 0x01, PRIO[1] = 2, THRESH = 0; hold `irq_src_i[0]` high → `ex_trap_o` = 1 two cycles later; read CLAIM → 1, `ex_trap_o` falls; write CLAIM = 1 with the line still high → re-pends, and `ex_trap_o` rises again.
- **Priority and tie-break:** PRIO[2] = 3, PRIO[5] = 3, PRIO[7] = 1, all enabled and pending → successive claims return 2, 5, 7, then 0.
- **Threshold:** THRESH = 3, PRIO[1] = 3, source pending → `ex_trap_o` stays 0 and CLAIM reads 0; set THRESH = 2 → `ex_trap_o` = 1.
- **Edge mode (`EIRQ_EDGE_EN`):** TRIG bit0 = 1; pulse `irq_src_i[0]` for 1 cycle → pending; claim; second pulse while in service → PENDING bit0 = 1 but CLAIM reads 0 until complete, then reads 1.
- **Bus handling:**
  - read 0x3C → `rsp_error` = 1, data 0;
  - hold `rsp_ready` = 0 for 5 cycles → `cmd_ready` = 0 and the response is held stable;
  - write ENABLE = 0xFFFF_FFFF with `cmd_wem` = 4'b0001 → ENABLE reads 0x0000_00FF when `SRC_NUM` = 8.
- **Reset mid-operation:** assert `rst` while a source is in service and `rsp_valid` = 1 → next cycle, all registers, `ex_trap_o` and `rsp_valid` are 0.

Source files
------------

// File: rtl/eirq_pkg.sv
// rtl/eirq_pkg.sv - Register offsets, decode selector and byte-mask helper for eirq_ctrl.
package eirq_pkg;

  localparam logic [7:0] EIRQ_PENDING   = 8'h00;
  localparam logic [7:0] EIRQ_ENABLE    = 8'h04;
  localparam logic [7:0] EIRQ_THRESH    = 8'h08;
  localparam logic [7:0] EIRQ_CLAIM     = 8'h0C;
  localparam logic [7:0] EIRQ_TRIG      = 8'h10;
  localparam logic [7:0] EIRQ_PRIO_BASE = 8'h40;

  localparam int EIRQ_ID_W           = 5;
  localparam int EIRQ_PRIO_BASE_WORD = int'(EIRQ_PRIO_BASE[7:2]);

  typedef enum logic [2:0] {
    REG_PENDING,
    REG_ENABLE,
    REG_THRESH,
    REG_CLAIM,
    REG_TRIG,
    REG_PRIO,
    REG_NONE
  } reg_sel_e;

  function automatic logic [31:0] wem_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  wem);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = wem[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/eirq_gateway.sv
// rtl/eirq_gateway.sv - Per-source pending/in-service tracking with level or edge capture.
// Edge capture flops exist only when EIRQ_EDGE_EN is defined.
module eirq_gateway (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_mode,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);

  logic edge_set;
  logic level_set;

`ifdef EIRQ_EDGE_EN
  logic src_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) src_q <= 1'b0;
    else     src_q <= src;
  end

  assign edge_set = src & ~src_q;
`else
  assign edge_set = 1'b0;
`endif

  assign level_set = src & ~in_service;

  // Edge set beats a same-cycle claim; a level claim wins so the source waits for complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      if (edge_mode & edge_set)       pending <= 1'b1;
      else if (claim)                 pending <= 1'b0;
      else if (~edge_mode & level_set) pending <= 1'b1;

      if (claim)         in_service <= 1'b1;
      else if (complete) in_service <= 1'b0;
    end
  end

endmodule

// File: rtl/eirq_ctrl.sv
// rtl/eirq_ctrl.sv - External interrupt controller: register port, arbitration, core request.
// Edge-triggered sources and the TRIG register are built when EIRQ_EDGE_EN is defined.
module eirq_ctrl
  import eirq_pkg::*;
#(
  parameter int SRC_NUM = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SRC_NUM-1:0] irq_src_i,
  output logic               ex_trap_o,
  input  logic [31:0]        cmd_addr,
  input  logic [31:0]        cmd_wdata,
  input  logic               cmd_we,
  input  logic [3:0]         cmd_wem,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_error
);

  logic [SRC_NUM-1:0]   enable_q;
  logic [SRC_NUM-1:0]   pending;
  logic [SRC_NUM-1:0]   in_service;
  logic [SRC_NUM-1:0]   claim_vec;
  logic [SRC_NUM-1:0]   complete_vec;
  logic [SRC_NUM-1:0]   edge_mode;
  logic [PRIO_W-1:0]    thresh_q;
  logic [PRIO_W-1:0]    prio_q [SRC_NUM];
  logic [EIRQ_ID_W-1:0] win_id_q;
  logic [EIRQ_ID_W-1:0] best_id;
  logic [EIRQ_ID_W-1:0] prio_idx;
  logic [PRIO_W-1:0]    best_prio;
  logic                 any_cand;
  reg_sel_e             sel;
  logic [5:0]           word;
  logic                 accept;
  logic                 wr_en;
  logic [31:0]          rd_data;
  logic [31:0]          wr_merged;
  logic                 rd_err;
  logic                 unused_bits;

  assign word      = cmd_addr[7:2];
  assign cmd_ready = ~rsp_valid;
  assign accept    = cmd_valid & ~rsp_valid;
  assign wr_en     = accept & cmd_we;

  always_comb begin
    sel      = REG_NONE;
    prio_idx = '0;
    if (word == EIRQ_PENDING[7:2])      sel = REG_PENDING;
    else if (word == EIRQ_ENABLE[7:2])  sel = REG_ENABLE;
    else if (word == EIRQ_THRESH[7:2])  sel = REG_THRESH;
    else if (word == EIRQ_CLAIM[7:2])   sel = REG_CLAIM;
    else if (word == EIRQ_TRIG[7:2])    sel = REG_TRIG;
    else if (int'(word) >= EIRQ_PRIO_BASE_WORD &&
             int'(word) <  EIRQ_PRIO_BASE_WORD + SRC_NUM) begin
      sel      = REG_PRIO;
      prio_idx = EIRQ_ID_W'(int'(word) - EIRQ_PRIO_BASE_WORD);
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (sel)
      REG_PENDING: rd_data[SRC_NUM-1:0]   = pending;
      REG_ENABLE:  rd_data[SRC_NUM-1:0]   = enable_q;
      REG_THRESH:  rd_data[PRIO_W-1:0]    = thresh_q;
      REG_CLAIM:   rd_data[EIRQ_ID_W-1:0] = win_id_q;
      REG_TRIG: begin
`ifdef EIRQ_EDGE_EN
        rd_data[SRC_NUM-1:0] = edge_mode;
`endif
      end
      REG_PRIO: begin
        for (int i = 0; i < SRC_NUM; i++) begin
          if (prio_idx == EIRQ_ID_W'(i)) rd_data[PRIO_W-1:0] = prio_q[i];
        end
      end
      default: rd_err = 1'b1;
    endcase
  end

  // Current register value doubles as the merge base for byte-masked writes.
  assign wr_merged   = wem_merge(rd_data, cmd_wdata, cmd_wem);
  assign unused_bits = ^{cmd_addr[31:8], cmd_addr[1:0], wr_merged};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q <= '0;
      thresh_q <= '0;
      for (int i = 0; i < SRC_NUM; i++) prio_q[i] <= '0;
    end else if (wr_en) begin
      if (sel == REG_ENABLE) enable_q <= wr_merged[SRC_NUM-1:0];
      if (sel == REG_THRESH) thresh_q <= wr_merged[PRIO_W-1:0];
      for (int i = 0; i < SRC_NUM; i++) begin
        if (sel == REG_PRIO && prio_idx == EIRQ_ID_W'(i)) prio_q[i] <= wr_merged[PRIO_W-1:0];
      end
    end
  end

`ifdef EIRQ_EDGE_EN
  logic [SRC_NUM-1:0] trig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              trig_q <= '0;
    else if (wr_en && sel == REG_TRIG)    trig_q <= wr_merged[SRC_NUM-1:0];
  end

  assign edge_mode = trig_q;
`else
  assign edge_mode = '0;
`endif

  for (genvar g = 0; g < SRC_NUM; g++) begin : g_src
    assign claim_vec[g]    = accept & ~cmd_we & (sel == REG_CLAIM) &
                             (win_id_q == EIRQ_ID_W'(g + 1));
    assign complete_vec[g] = wr_en & (sel == REG_CLAIM) &
                             (cmd_wdata[EIRQ_ID_W-1:0] == EIRQ_ID_W'(g + 1));

    eirq_gateway u_gw (
      .clk        (clk),
      .rst        (rst),
      .src        (irq_src_i[g]),
      .edge_mode  (edge_mode[g]),
      .claim      (claim_vec[g]),
      .complete   (complete_vec[g]),
      .pending    (pending[g]),
      .in_service (in_service[g])
    );
  end

  // Strict compare keeps the lowest ID on equal priority.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    any_cand  = 1'b0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (pending[i] && enable_q[i] && !in_service[i] && prio_q[i] > thresh_q) begin
        any_cand = 1'b1;
        if (prio_q[i] > best_prio) begin
          best_prio = prio_q[i];
          best_id   = EIRQ_ID_W'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_id_q  <= '0;
      ex_trap_o <= 1'b0;
    end else begin
      win_id_q  <= best_id;
      ex_trap_o <= any_cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= cmd_we ? 32'h0 : rd_data;
      rsp_error <= rd_err;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eirq_ctrl.sv
// tb/tb_eirq_ctrl.sv - Directed self-checking bench for eirq_ctrl.
module tb_eirq_ctrl;

  localparam int SRC_NUM = 8;
  localparam int PRIO_W  = 3;

  localparam logic [31:0] A_PEND  = 32'h00;
  localparam logic [31:0] A_EN    = 32'h04;
  localparam logic [31:0] A_TH    = 32'h08;
  localparam logic [31:0] A_CLAIM = 32'h0C;
  localparam logic [31:0] A_TRIG  = 32'h10;

  logic               clk = 1'b0;
  logic               rst;
  logic [SRC_NUM-1:0] irq_src_i;
  logic               ex_trap_o;
  logic [31:0]        cmd_addr;
  logic [31:0]        cmd_wdata;
  logic               cmd_we;
  logic [3:0]         cmd_wem;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [31:0]        rsp_rdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  eirq_ctrl #(.SRC_NUM(SRC_NUM), .PRIO_W(PRIO_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src_i (irq_src_i),
    .ex_trap_o (ex_trap_o),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_we    (cmd_we),
    .cmd_wem   (cmd_wem),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_error (rsp_error)
  );

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic we,
                     input logic [3:0] wem, output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    cmd_addr = a; cmd_wdata = d; cmd_we = we; cmd_wem = wem;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bus_timeout addr=%h got rsp_valid=%b need 1", a, rsp_valid);
    end
    rd = rsp_rdata;
    er = rsp_error;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] x;
    logic e;
    bus(a, d, 1'b1, 4'hF, x, e);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic e);
    bus(a, 32'h0, 1'b0, 4'h0, d, e);
  endtask

  task automatic pulse(input logic [SRC_NUM-1:0] v);
    @(negedge clk);
    irq_src_i = v;
    @(negedge clk);
    irq_src_i = '0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic e;
    logic [31:0] addrs [5];
    addrs = '{A_PEND, A_EN, A_TH, A_CLAIM, 32'h40};
    rst = 1'b1; irq_src_i = '0; cmd_addr = '0; cmd_wdata = '0; cmd_we = 1'b0;
    cmd_wem = '0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({ex_trap_o, rsp_valid, rsp_error, cmd_ready} !== 4'b0001 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got trap/rv/re/cr=%b%b%b%b rdata=%h need 0001 rdata=0",
               ex_trap_o, rsp_valid, rsp_error, cmd_ready, rsp_rdata);
    end
    for (int k = 0; k < 5; k++) begin
      rd(addrs[k], d, e);
      n_checks++;
      if (d !== 32'h0 || e !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_reg addr=%h got %h err=%b need 0 err=0", addrs[k], d, e);
      end
    end
  endtask

  task automatic test_level_source;
    logic [31:0] d;
    logic e;
    wr(A_EN, 32'h1); wr(32'h40, 32'h2); wr(A_TH, 32'h0);
    irq_src_i[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ex_trap_o !== 1'b0) begin n_fail++; $display("FAIL level_lat_n1 got %b need 0", ex_trap_o); end
    @(negedge clk);
    n_checks++;
    if (ex_trap_o !== 1'b1) begin n_fail++; $display("FAIL level_lat_n2 got %b need 1", ex_trap_o); end
    rd(A_CLAIM, d, e);
    n_checks++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL level_claim got %0d need 1", d); end
    n_checks++;
    if (ex_trap_o !== 1'b1) begin n_fail++; $display("FAIL level_claim_n1 got %b need 1", ex_trap_o); end
    @(negedge clk);
    n_checks++;
    if (ex_trap_o !== 1'b0) begin n_fail++; $display("FAIL level_claim_n2 got %b need 0", ex_trap_o); end
    wr(A_CLAIM, 32'd1);
    @(negedge clk);
    n_checks++;
    if (ex_trap_o !== 1'b0) begin n_fail++; $display("FAIL level_repend_n2 got %b need 0", ex_trap_o); end
    @(negedge clk);
    n_checks++;
    if (ex_trap_o !== 1'b1) begin n_fail++; $display("FAIL level_repend_n3 got %b need 1", ex_trap_o); end
    rd(A_PEND, d, e);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL level_pending got %h need 1", d); end
    rd(A_CLAIM, d, e);
    irq_src_i[0] = 1'b0;
    wr(A_CLAIM, 32'd1);
    repeat (3) @(negedge clk);
    rd(A_PEND, d, e);
    n_checks++;
    if (d !== 32'h0 || ex_trap_o !== 1'b0) begin
      n_fail++;
      $display("FAIL level_idle got pend=%h trap=%b need 0 0", d, ex_trap_o);
    end
  endtask

  task automatic test_priority;
    logic [31:0] d;
    logic e;
    int exp_ids [4];
    exp_ids = '{2, 5, 7, 0};
    wr(32'h40, 32'h0); wr(A_EN, 32'hFF);
    wr(32'h44, 32'h3); wr(32'h50, 32'h3); wr(32'h58, 32'h1);
    pulse(8'b0101_0010);
    repeat (2) @(negedge clk);
    rd(A_PEND, d, e);
    n_checks++;
    if (d !== 32'h52) begin n_fail++; $display("FAIL prio_pending got %h need 52", d); end
    for (int k = 0; k < 4; k++) begin
      rd(A_CLAIM, d, e);
      n_checks++;
      if (d !== 32'(exp_ids[k])) begin
        n_fail++;
        $display("FAIL prio_claim_%0d got %0d need %0d", k, d, exp_ids[k]);
      end
    end
    bus(A_CLAIM, 32'd9, 1'b1, 4'hF, d, e);
    n_checks++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL complete_oob_err got %b need 0", e); end
    wr(A_CLAIM, 32'd2); wr(A_CLAIM, 32'd5); wr(A_CLAIM, 32'd7);
    repeat (3) @(negedge clk);
    n_checks++;
    if (ex_trap_o !== 1'b0) begin n_fail++; $display("FAIL prio_idle_trap got %b need 0", ex_trap_o); end
  endtask

  task automatic test_threshold;
    logic [31:0] d;
    logic e;
    wr(A_TH, 32'h3); wr(32'h40, 32'h3);
    pulse(8'h01);
    repeat (3) @(negedge clk);
    n_checks++;
    if (ex_trap_o !== 1'b0) begin n_fail++; $display("FAIL thresh_block_trap got %b need 0", ex_trap_o); end
    rd(A_CLAIM, d, e);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL thresh_block_claim got %0d need 0", d); end
    wr(A_TH, 32'h2);
    @(negedge clk);
    n_checks++;
    if (ex_trap_o !== 1'b1) begin n_fail++; $display("FAIL thresh_open_trap got %b need 1", ex_trap_o); end
    rd(A_CLAIM, d, e);
    n_checks++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL thresh_open_claim got %0d need 1", d); end
    wr(A_CLAIM, 32'd1); wr(A_TH, 32'h0);
  endtask

  task automatic test_trig;
    logic [31:0] d;
    logic e;
`ifdef EIRQ_EDGE_EN
    wr(A_TRIG, 32'h1);
    rd(A_TRIG, d, e);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL trig_rw got %h need 1", d); end
    pulse(8'h01);
    repeat (2) @(negedge clk);
    rd(A_CLAIM, d, e);
    n_checks++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL edge_claim1 got %0d need 1", d); end
    pulse(8'h01);
    repeat (2) @(negedge clk);
    rd(A_PEND, d, e);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL edge_pend_in_service got %h need 1", d); end
    rd(A_CLAIM, d, e);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL edge_claim_blocked got %0d need 0", d); end
    wr(A_CLAIM, 32'd1);
    repeat (2) @(negedge clk);
    rd(A_CLAIM, d, e);
    n_checks++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL edge_claim2 got %0d need 1", d); end
    wr(A_CLAIM, 32'd1); wr(A_TRIG, 32'h0);
`else
    wr(A_TRIG, 32'hFF);
    rd(A_TRIG, d, e);
    n_checks++;
    if (d !== 32'h0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL trig_absent got %h err=%b need 0 err=0", d, e);
    end
`endif
  endtask

  task automatic test_bus;
    logic [31:0] d;
    logic [31:0] held;
    logic e;
    logic [31:0] bad [3];
    bad = '{32'h3C, 32'h14, 32'h60};
    for (int k = 0; k < 3; k++) begin
      rd(bad[k], d, e);
      n_checks++;
      if (d !== 32'h0 || e !== 1'b1) begin
        n_fail++;
        $display("FAIL unmapped addr=%h got %h err=%b need 0 err=1", bad[k], d, e);
      end
    end
    wr(A_EN, 32'h0);
    bus(A_EN, 32'hFFFF_FFFF, 1'b1, 4'b0001, d, e);
    bus(A_EN, 32'h0, 1'b1, 4'b0010, d, e);
    rd(A_EN, d, e);
    n_checks++;
    if (d !== 32'hFF) begin n_fail++; $display("FAIL wem_enable got %h need ff", d); end
    wr(A_PEND, 32'hFF);
    rd(A_PEND, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL pending_ro got %h need 0", d); end
    @(negedge clk);
    cmd_addr = A_EN; cmd_we = 1'b0; cmd_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    held = rsp_rdata;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_rdata !== 32'hFF || rsp_rdata !== held) begin
        n_fail++;
        $display("FAIL hold_%0d got rv=%b cr=%b rdata=%h need rv=1 cr=0 rdata=ff",
                 k, rsp_valid, cmd_ready, rsp_rdata);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release got rv=%b cr=%b need rv=0 cr=1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic e;
    wr(32'h40, 32'h3); wr(32'h44, 32'h3); wr(A_EN, 32'hFF);
    pulse(8'h03);
    repeat (2) @(negedge clk);
    rd(A_CLAIM, d, e);
    repeat (2) @(negedge clk);
    n_checks++;
    if (d !== 32'd1 || ex_trap_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_setup got claim=%0d trap=%b need 1 1", d, ex_trap_o);
    end
    cmd_addr = A_EN; cmd_we = 1'b0; cmd_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ex_trap_o, rsp_valid, rsp_error} !== 3'b000 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got trap/rv/re=%b%b%b rdata=%h need 000 0",
               ex_trap_o, rsp_valid, rsp_error, rsp_rdata);
    end
    rst = 1'b0; rsp_ready = 1'b1;
    rd(A_EN, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_enable got %h need 0", d); end
    rd(32'h44, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_prio got %h need 0", d); end
    rd(A_PEND, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_pending got %h need 0", d); end
    wr(A_EN, 32'h1); wr(32'h40, 32'h1);
    pulse(8'h01);
    repeat (2) @(negedge clk);
    rd(A_CLAIM, d, e);
    n_checks++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL rstmid_inservice_cleared got %0d need 1", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_level_source();
    test_priority();
    test_threshold();
    test_trig();
    test_bus();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
